// File: rtl/hash_table_oa_if.sv
// hash_table_oa_if
//   Request/response bundle for the open-addressing hash table.
//   master : the requester (drives key_in, value_in, op_sel, op_en;
//            observes op_ready, op_done, op_error, value_out,
//            probe_count, entry_count)
//   slave  : the hash table itself (the reverse directions)
//   key_in / value_in  operand key and insert value
//   op_sel             00 insert, 01 delete, 10 search, 11 clear
//   op_en / op_ready   request strobe, accepted while op_ready is high
//   op_done / op_error one-cycle completion pulse with its error flag
//   value_out          last successful search result
//   probe_count        slots examined minus one by the last op
//   entry_count        live count of VALID slots
interface hash_table_oa_if #(
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 32,
  parameter int TOTAL_SLOTS = 8
);
  localparam int IW = $clog2(TOTAL_SLOTS);

  logic [KEY_WIDTH-1:0]   key_in;
  logic [VALUE_WIDTH-1:0] value_in;
  logic [1:0]             op_sel;
  logic                   op_en;
  logic                   op_ready;
  logic [VALUE_WIDTH-1:0] value_out;
  logic                   op_done;
  logic                   op_error;
  logic [IW:0]            probe_count;
  logic [IW:0]            entry_count;

  modport master (
    output key_in, value_in, op_sel, op_en,
    input  op_ready, value_out, op_done, op_error, probe_count, entry_count
  );

  modport slave (
    input  key_in, value_in, op_sel, op_en,
    output op_ready, value_out, op_done, op_error, probe_count, entry_count
  );
endinterface

// File: rtl/hash_table_oa.sv
// hash_table_oa
//   Open-addressing key/value hash table with linear probing and tombstone
//   deletion. One slot is examined per cycle; insert, delete, search and
//   clear are issued through the hash_table_oa_if slave modport.
//   clk    clock
//   rst_n  asynchronous active-low reset; empties the table and aborts any
//          operation in flight without a completion pulse
//   bus    request/response interface (see hash_table_oa_if)
module hash_table_oa #(
  parameter int    KEY_WIDTH      = 32,
  parameter int    VALUE_WIDTH    = 32,
  parameter int    TOTAL_SLOTS    = 8,
  parameter int    MAX_PROBE      = TOTAL_SLOTS,
  parameter string HASH_ALGORITHM = "MODULUS"
) (
  input  logic clk,
  input  logic rst_n,
  hash_table_oa_if.slave bus
);
  localparam int IW = $clog2(TOTAL_SLOTS);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST_PROBE = CW'(MAX_PROBE - 1);

  localparam logic [1:0] OP_INS = 2'b00;
  localparam logic [1:0] OP_DEL = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [2:0] {IDLE, HASH, PROBE, CLEAR, DONE} state_t;
  typedef enum logic [1:0] {S_EMPTY, S_VALID, S_TOMB} slot_t;

  state_t state_q, state_d;

  logic [1:0]             op_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [VALUE_WIDTH-1:0] val_q;
  logic [IW-1:0]          idx_q;
  logic [CW-1:0]          pcnt_q;      // slots already examined this op
  logic                   ff_vld_q;    // a tombstone has been seen (insert)
  logic [IW-1:0]          ff_idx_q;
  slot_t                  slot_q [TOTAL_SLOTS];
  logic [KEY_WIDTH-1:0]   key_mem [TOTAL_SLOTS];
  logic [VALUE_WIDTH-1:0] val_mem [TOTAL_SLOTS];
  logic [CW-1:0]          count_q;
  logic [VALUE_WIDTH-1:0] vout_q;
  logic                   err_q;
  logic [CW-1:0]          pc_q;

  logic          capture, match, last, fin;
  logic          wr_new, wr_upd, del_hit, srch_hit, err;
  logic [IW-1:0] wr_idx;
  slot_t         cur;

  function automatic logic [IW-1:0] hash_idx(input logic [KEY_WIDTH-1:0] k);
    logic [31:0]          h;
    logic [KEY_WIDTH+7:0] kx;
    if (HASH_ALGORITHM == "FNV1A") begin
      // Zero-pad so the last partial byte of an odd-width key is well defined.
      kx = {8'd0, k};
      h  = 32'h811C9DC5;
      for (int i = 0; i < (KEY_WIDTH + 7) / 8; i++)
        h = (h ^ {24'd0, kx[8*i +: 8]}) * 32'h01000193;
      return h[IW-1:0];
    end
    return k[IW-1:0];
  endfunction

  assign capture = (state_q == IDLE) && bus.op_en;
  assign cur     = slot_q[idx_q];
  assign match   = (cur == S_VALID) && (key_mem[idx_q] == key_q);
  assign last    = (pcnt_q == LAST_PROBE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fin      = 1'b0;
    wr_new   = 1'b0;
    wr_upd   = 1'b0;
    wr_idx   = idx_q;
    del_hit  = 1'b0;
    srch_hit = 1'b0;
    err      = 1'b0;
    case (state_q)
      IDLE:  if (bus.op_en) state_d = (bus.op_sel == OP_CLR) ? CLEAR : HASH;
      HASH:  state_d = PROBE;
      PROBE: begin
        // An EMPTY slot ends the chain; the probe budget ends it too.
        fin = match || (cur == S_EMPTY) || last;
        if (fin) state_d = DONE;
        case (op_q)
          OP_INS: begin
            if (match) wr_upd = 1'b1;
            else if (fin) begin
              if (ff_vld_q) begin
                wr_new = 1'b1;
                wr_idx = ff_idx_q;
              end else if (cur != S_VALID) begin
                // EMPTY here, or a TOMB met on the final permitted probe.
                wr_new = 1'b1;
              end else begin
                err = 1'b1;
              end
            end
          end
          OP_DEL: begin
            if (match)    del_hit = 1'b1;
            else if (fin) err     = 1'b1;
          end
          default: begin
            if (match)    srch_hit = 1'b1;
            else if (fin) err      = 1'b1;
          end
        endcase
      end
      CLEAR: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Key/value storage and operand latches carry no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      key_q <= bus.key_in;
      val_q <= bus.value_in;
    end
    if (wr_new || wr_upd) val_mem[wr_idx] <= val_q;
    if (wr_new)           key_mem[wr_idx] <= key_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      idx_q    <= '0;
      pcnt_q   <= '0;
      ff_vld_q <= 1'b0;
      ff_idx_q <= '0;
      count_q  <= '0;
      vout_q   <= '0;
      err_q    <= 1'b0;
      pc_q     <= '0;
      for (int i = 0; i < TOTAL_SLOTS; i++) slot_q[i] <= S_EMPTY;
    end else begin
      if (capture) op_q <= bus.op_sel;
      if (state_q == HASH) begin
        idx_q    <= hash_idx(key_q);
        pcnt_q   <= '0;
        ff_vld_q <= 1'b0;
      end
      if (state_q == PROBE) begin
        idx_q  <= idx_q + IW'(1);
        pcnt_q <= pcnt_q + CW'(1);
        // Remember the earliest tombstone so an insert can reuse it.
        if (op_q == OP_INS && cur == S_TOMB && !ff_vld_q) begin
          ff_vld_q <= 1'b1;
          ff_idx_q <= idx_q;
        end
        if (fin) begin
          err_q <= err;
          pc_q  <= pcnt_q;
        end
      end
      if (wr_new) begin
        slot_q[wr_idx] <= S_VALID;
        count_q        <= count_q + CW'(1);
      end
      if (del_hit) begin
        slot_q[idx_q] <= S_TOMB;
        count_q       <= count_q - CW'(1);
      end
      if (srch_hit) vout_q <= val_mem[idx_q];
      if (state_q == CLEAR) begin
        for (int i = 0; i < TOTAL_SLOTS; i++) slot_q[i] <= S_EMPTY;
        count_q <= '0;
        err_q   <= 1'b0;
        pc_q    <= '0;
      end
    end
  end

  assign bus.op_ready    = (state_q == IDLE);
  assign bus.op_done     = (state_q == DONE);
  assign bus.op_error    = err_q;
  assign bus.value_out   = vout_q;
  assign bus.probe_count = pc_q;
  assign bus.entry_count = count_q;
endmodule

// File: tb/tb_hash_table_oa.sv
module tb_hash_table_oa;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hash_table_oa_if #(.KEY_WIDTH(32), .VALUE_WIDTH(32), .TOTAL_SLOTS(N)) bus ();

  hash_table_oa #(
    .KEY_WIDTH(32), .VALUE_WIDTH(32), .TOTAL_SLOTS(N),
    .MAX_PROBE(N), .HASH_ALGORITHM("MODULUS")
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: 0 = empty, 1 = valid, 2 = tombstone.
  int          m_st  [N];
  logic [31:0] m_key [N];
  logic [31:0] m_val [N];
  int          m_cnt;
  logic [31:0] m_vout;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_st[i] = 0;
    m_cnt  = 0;
    m_vout = '0;
  endtask

  task automatic model_op(input logic [1:0] op, input logic [31:0] k, input logic [31:0] v,
                          output logic e_err, output int e_pc);
    int h, hit, emp, ff, s, slot;
    e_err = 1'b0;
    e_pc  = 0;
    if (op == 2'b11) begin
      for (int i = 0; i < N; i++) m_st[i] = 0;
      m_cnt = 0;
      return;
    end
    h = int'(k % N); hit = -1; emp = -1; ff = -1;
    for (int i = 0; i < N; i++) begin
      s = (h + i) % N;
      if (m_st[s] == 1 && m_key[s] == k) begin hit = i; break; end
      if (m_st[s] == 0) begin emp = i; break; end
      if (m_st[s] == 2 && ff < 0) ff = s;
    end
    e_pc = (hit >= 0) ? hit : (emp >= 0) ? emp : N - 1;
    case (op)
      2'b00: begin
        if (hit >= 0) m_val[(h + hit) % N] = v;
        else begin
          slot = (ff >= 0) ? ff : (emp >= 0) ? (h + emp) % N : -1;
          if (slot < 0) e_err = 1'b1;
          else begin
            m_st[slot] = 1; m_key[slot] = k; m_val[slot] = v; m_cnt++;
          end
        end
      end
      2'b01: begin
        if (hit >= 0) begin m_st[(h + hit) % N] = 2; m_cnt--; end
        else e_err = 1'b1;
      end
      default: begin
        if (hit >= 0) m_vout = m_val[(h + hit) % N];
        else e_err = 1'b1;
      end
    endcase
  endtask

  // Issue one op from a negedge and return what the DUT reports with op_done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] k, input logic [31:0] v,
                        output int lat, output logic err, output logic [3:0] pc,
                        output logic [31:0] vo, output logic [3:0] cnt);
    int g = 0;
    while (bus.op_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    bus.op_sel = op; bus.key_in = k; bus.value_in = v; bus.op_en = 1'b1;
    @(posedge clk);
    #1 bus.op_en = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.op_done === 1'b1) begin lat = c; break; end
    end
    err = bus.op_error; pc = bus.probe_count; vo = bus.value_out; cnt = bus.entry_count;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.op_ready, bus.op_done, bus.op_error, bus.probe_count, bus.entry_count} !== 11'b100_0000_0000
        || bus.value_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got rdy=%b done=%b err=%b pc=%0d cnt=%0d vo=%0d expected 1 0 0 0 0 0",
               bus.op_ready, bus.op_done, bus.op_error, bus.probe_count, bus.entry_count, bus.value_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.op_ready, bus.op_done, bus.entry_count} !== 6'b10_0000) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b done=%b cnt=%0d expected 1 0 0",
               bus.op_ready, bus.op_done, bus.entry_count);
    end
  endtask

  // Rows: op, key, value, expected error, probe_count, value_out, entry_count.
  task automatic test_insert_search();
    int op[4] = '{0, 0, 0, 2};
    int k [4] = '{1, 9, 17, 9};
    int v [4] = '{2, 3, 4, 0};
    int ee[4] = '{0, 0, 0, 0};
    int ep[4] = '{0, 1, 2, 1};
    int eo[4] = '{0, 0, 0, 3};
    int ec[4] = '{1, 2, 3, 3};
    int lat; logic err; logic [3:0] pc, cnt; logic [31:0] vo;
    for (int i = 0; i < 4; i++) begin
      run_op(2'(op[i]), 32'(k[i]), 32'(v[i]), lat, err, pc, vo, cnt);
      n_chk++;
      if (err !== 1'(ee[i]) || pc !== 4'(ep[i]) || vo !== 32'(eo[i]) || cnt !== 4'(ec[i]) || lat != ep[i] + 3) begin
        n_fail++;
        $display("FAIL insert_search[%0d]: got err=%0d pc=%0d vo=%0d cnt=%0d lat=%0d expected %0d %0d %0d %0d %0d",
                 i, err, pc, vo, cnt, lat, ee[i], ep[i], eo[i], ec[i], ep[i] + 3);
      end
    end
  endtask

  task automatic test_delete_tombstone();
    int op[5] = '{1, 2, 2, 0, 2};
    int k [5] = '{9, 17, 9, 25, 25};
    int v [5] = '{0, 0, 0, 7, 0};
    int ee[5] = '{0, 0, 1, 0, 0};
    int ep[5] = '{1, 2, 3, 3, 1};
    int eo[5] = '{3, 4, 4, 4, 7};
    int ec[5] = '{2, 2, 2, 3, 3};
    int lat; logic err; logic [3:0] pc, cnt; logic [31:0] vo;
    for (int i = 0; i < 5; i++) begin
      run_op(2'(op[i]), 32'(k[i]), 32'(v[i]), lat, err, pc, vo, cnt);
      n_chk++;
      if (err !== 1'(ee[i]) || pc !== 4'(ep[i]) || vo !== 32'(eo[i]) || cnt !== 4'(ec[i]) || lat != ep[i] + 3) begin
        n_fail++;
        $display("FAIL delete_tomb[%0d]: got err=%0d pc=%0d vo=%0d cnt=%0d lat=%0d expected %0d %0d %0d %0d %0d",
                 i, err, pc, vo, cnt, lat, ee[i], ep[i], eo[i], ec[i], ep[i] + 3);
      end
    end
  endtask

  task automatic test_wrap_update();
    int op[5] = '{0, 0, 2, 0, 2};
    int k [5] = '{7, 15, 15, 1, 1};
    int v [5] = '{1, 2, 0, 99, 0};
    int ee[5] = '{0, 0, 0, 0, 0};
    int ep[5] = '{0, 1, 1, 0, 0};
    int eo[5] = '{7, 7, 2, 2, 99};
    int ec[5] = '{4, 5, 5, 5, 5};
    int lat; logic err; logic [3:0] pc, cnt; logic [31:0] vo;
    for (int i = 0; i < 5; i++) begin
      run_op(2'(op[i]), 32'(k[i]), 32'(v[i]), lat, err, pc, vo, cnt);
      n_chk++;
      if (err !== 1'(ee[i]) || pc !== 4'(ep[i]) || vo !== 32'(eo[i]) || cnt !== 4'(ec[i]) || lat != ep[i] + 3) begin
        n_fail++;
        $display("FAIL wrap_update[%0d]: got err=%0d pc=%0d vo=%0d cnt=%0d lat=%0d expected %0d %0d %0d %0d %0d",
                 i, err, pc, vo, cnt, lat, ee[i], ep[i], eo[i], ec[i], ep[i] + 3);
      end
    end
  endtask

  task automatic test_full_table();
    int op[5] = '{0, 0, 0, 0, 2};
    int k [5] = '{4, 5, 6, 33, 33};
    int v [5] = '{40, 50, 60, 5, 0};
    int ee[5] = '{0, 0, 0, 1, 1};
    int ep[5] = '{0, 0, 0, 7, 7};
    int eo[5] = '{99, 99, 99, 99, 99};
    int ec[5] = '{6, 7, 8, 8, 8};
    int lat; logic err; logic [3:0] pc, cnt; logic [31:0] vo;
    for (int i = 0; i < 5; i++) begin
      run_op(2'(op[i]), 32'(k[i]), 32'(v[i]), lat, err, pc, vo, cnt);
      n_chk++;
      if (err !== 1'(ee[i]) || pc !== 4'(ep[i]) || vo !== 32'(eo[i]) || cnt !== 4'(ec[i]) || lat != ep[i] + 3) begin
        n_fail++;
        $display("FAIL full_table[%0d]: got err=%0d pc=%0d vo=%0d cnt=%0d lat=%0d expected %0d %0d %0d %0d %0d",
                 i, err, pc, vo, cnt, lat, ee[i], ep[i], eo[i], ec[i], ep[i] + 3);
      end
    end
  endtask

  task automatic test_op_en_held();
    int dones = 0;
    logic [31:0] vo = '0;
    bus.op_sel = 2'b10; bus.key_in = 32'd4; bus.op_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.op_done === 1'b1) begin
        dones++;
        vo = bus.value_out;
        bus.op_en = 1'b0;
      end
    end
    bus.op_en = 1'b0;
    n_chk++;
    if (dones != 1 || vo !== 32'd40) begin
      n_fail++;
      $display("FAIL op_en_held: got dones=%0d vo=%0d expected 1 40", dones, vo);
    end
  endtask

  task automatic test_clear();
    int lat; logic err; logic [3:0] pc, cnt; logic [31:0] vo;
    run_op(2'b11, 32'd0, 32'd0, lat, err, pc, vo, cnt);
    n_chk++;
    if (lat != 2 || cnt !== 4'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: got lat=%0d cnt=%0d err=%0d expected 2 0 0", lat, cnt, err);
    end
    run_op(2'b10, 32'd1, 32'd0, lat, err, pc, vo, cnt);
    n_chk++;
    if (err !== 1'b1 || pc !== 4'd0 || cnt !== 4'd0 || vo !== 32'd40 || lat != 3) begin
      n_fail++;
      $display("FAIL clear_search: got err=%0d pc=%0d cnt=%0d vo=%0d lat=%0d expected 1 0 0 40 3",
               err, pc, cnt, vo, lat);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic err; logic [3:0] pc, cnt; logic [31:0] vo;
    int dones = 0;
    int keys[3] = '{3, 11, 19};
    run_op(2'b00, 32'd3, 32'd30, lat, err, pc, vo, cnt);
    run_op(2'b00, 32'd11, 32'd31, lat, err, pc, vo, cnt);
    @(negedge clk);
    bus.op_sel = 2'b10; bus.key_in = 32'd19; bus.op_en = 1'b1;
    @(posedge clk);
    #1 bus.op_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.op_ready !== 1'b1 || bus.op_done !== 1'b0 || bus.entry_count !== 4'd0 || bus.value_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: got rdy=%b done=%b cnt=%0d vo=%0d expected 1 0 0 0",
               bus.op_ready, bus.op_done, bus.entry_count, bus.value_out);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.op_done === 1'b1) dones++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.op_done === 1'b1) dones++;
    end
    n_chk++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got dones=%0d expected 0", dones);
    end
    for (int i = 0; i < 3; i++) begin
      run_op(2'b10, 32'(keys[i]), 32'd0, lat, err, pc, vo, cnt);
      n_chk++;
      if (err !== 1'b1 || cnt !== 4'd0 || vo !== 32'd0 || lat != 3) begin
        n_fail++;
        $display("FAIL reset_search[%0d]: got err=%0d cnt=%0d vo=%0d lat=%0d expected 1 0 0 3",
                 i, err, cnt, vo, lat);
      end
    end
    model_reset();
  endtask

  task automatic test_random();
    int lat, e_pc, e_lat, r;
    logic err, e_err; logic [3:0] pc, cnt; logic [31:0] vo, k, v;
    logic [1:0] op;
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 99);
      op = (r < 45) ? 2'b00 : (r < 65) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
      k  = 32'($urandom_range(0, 19));
      v  = $urandom;
      model_op(op, k, v, e_err, e_pc);
      e_lat = (op == 2'b11) ? 2 : e_pc + 3;
      run_op(op, k, v, lat, err, pc, vo, cnt);
      n_chk++;
      if (err !== e_err || cnt !== 4'(m_cnt) || vo !== m_vout || lat != e_lat
          || (op != 2'b11 && pc !== 4'(e_pc))) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d key=%0d: got err=%0d pc=%0d cnt=%0d vo=%h lat=%0d expected %0d %0d %0d %h %0d",
                 i, op, k, err, pc, cnt, vo, lat, e_err, e_pc, m_cnt, m_vout, e_lat);
      end
    end
  endtask

  initial begin
    bus.key_in = '0; bus.value_in = '0; bus.op_sel = '0; bus.op_en = 1'b0;
    model_reset();
    test_reset();
    test_insert_search();
    test_delete_tombstone();
    test_wrap_update();
    test_full_table();
    test_op_en_held();
    test_clear();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
